// File: rtl/lif_frame_capture.sv
// lif_frame_capture
//   Captures a row of NCELLS 4-bit lif lattice cell states on a snapshot
//   request, streams them out one cell per beat over valid/ready, and
//   reports the frame's total particle count (popcount of all state bits)
//   at frame end, together with a wrapping completed-frame counter.
//
//   Build option: define LIF_CAPTURE_SKIP_EMPTY_EN to suppress beats for
//   empty (4'b0000) cells. out_idx then carries the true cell index, and an
//   all-empty capture goes straight to frame end with pop_count = 0.
//
// Ports
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   cells_in   in   packed cell states, cell k at [4k+3:4k]
//   snap       in   capture request, sampled every cycle
//   busy       out  a frame is held or streaming
//   out_valid  out  stream beat valid
//   out_ready  in   sink accepts beat
//   out_data   out  cell state of current beat
//   out_idx    out  cell index of current beat
//   out_last   out  current beat is the final beat of the frame
//   pop_valid  out  one-cycle pulse, pop_count is the new frame total
//   pop_count  out  total set bits in the last completed frame
//   frame_cnt  out  completed frames, wraps
//   overrun    out  sticky: snap seen while busy
module lif_frame_capture #(
    parameter  int NCELLS = 8,
    parameter  int FCNT_W = 8,
    localparam int IW     = $clog2(NCELLS),
    localparam int PW     = $clog2(4*NCELLS+1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*NCELLS-1:0]   cells_in,
    input  logic                  snap,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_data,
    output logic [IW-1:0]         out_idx,
    output logic                  out_last,
    output logic                  pop_valid,
    output logic [PW-1:0]         pop_count,
    output logic [FCNT_W-1:0]     frame_cnt,
    output logic                  overrun
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]          state_q;
    logic [4*NCELLS-1:0] cap_q;
    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       last_q;
    logic [PW-1:0]       acc_q;
    logic [PW-1:0]       pop_q;
    logic [FCNT_W-1:0]   fcnt_q;
    logic                ovr_q;

    logic [IW-1:0]       first_idx;
    logic [IW-1:0]       last_idx_in;
    logic [IW-1:0]       next_idx;
    logic                any_in;
    logic [PW-1:0]       acc_sum;
    logic                beat_last;

`ifdef LIF_CAPTURE_SKIP_EMPTY_EN
    logic [NCELLS-1:0]   mask_in;
    logic [NCELLS-1:0]   mask_q;
`endif

    function automatic logic [2:0] popcnt4(input logic [3:0] d);
        return {2'b00, d[0]} + {2'b00, d[1]} + {2'b00, d[2]} + {2'b00, d[3]};
    endfunction

    assign out_data  = cap_q[4*idx_q +: 4];
    assign out_idx   = idx_q;
    assign out_valid = (state_q == STREAM);
    assign busy      = (state_q != IDLE);
    assign beat_last = (idx_q == last_q);
    // Qualified by STREAM so a stale index left from the previous frame
    // never presents a last flag outside a transfer window.
    assign out_last  = out_valid && beat_last;
    assign pop_valid = (state_q == DONE);
    assign pop_count = pop_q;
    assign frame_cnt = fcnt_q;
    assign overrun   = ovr_q;
    assign acc_sum   = acc_q + PW'(popcnt4(out_data));

    // Beat sequencing: first/last index of a fresh capture and the index
    // following the current beat.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch,
        // otherwise paths that skip an assignment infer a latch.
`ifdef LIF_CAPTURE_SKIP_EMPTY_EN
        first_idx   = '0;
        last_idx_in = '0;
        next_idx    = idx_q;
        for (int k = 0; k < NCELLS; k++)
            mask_in[k] = |cells_in[4*k +: 4];
        // Descending scan leaves the lowest non-empty index behind.
        for (int k = NCELLS-1; k >= 0; k--)
            if (mask_in[k]) first_idx = IW'(k);
        for (int k = 0; k < NCELLS; k++)
            if (mask_in[k]) last_idx_in = IW'(k);
        for (int k = NCELLS-1; k >= 0; k--)
            if (mask_q[k] && (k > int'(idx_q))) next_idx = IW'(k);
        any_in = |mask_in;
`else
        first_idx   = '0;
        last_idx_in = IW'(NCELLS-1);
        next_idx    = idx_q + 1'b1;
        any_in      = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // registers update together from pre-edge values.
        if (!rst_n) begin
            // NOTE: the capture register is cleared on reset (not left as
            // don't-care) so out_data reads 0 straight out of reset.
            state_q <= IDLE;
            cap_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            acc_q   <= '0;
            pop_q   <= '0;
            fcnt_q  <= '0;
            ovr_q   <= 1'b0;
`ifdef LIF_CAPTURE_SKIP_EMPTY_EN
            mask_q  <= '0;
`endif
        end else begin
            if (snap && (state_q != IDLE))
                ovr_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (snap) begin
                        cap_q  <= cells_in;
                        idx_q  <= first_idx;
                        last_q <= last_idx_in;
                        acc_q  <= '0;
`ifdef LIF_CAPTURE_SKIP_EMPTY_EN
                        mask_q <= mask_in;
`endif
                        if (any_in) begin
                            state_q <= STREAM;
                        end else begin
                            // Nothing to emit: the frame completes at once.
                            state_q <= DONE;
                            pop_q   <= '0;
                            fcnt_q  <= fcnt_q + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        acc_q <= acc_sum;
                        if (beat_last) begin
                            state_q <= DONE;
                            pop_q   <= acc_sum;
                            fcnt_q  <= fcnt_q + 1'b1;
                        end else begin
                            idx_q <= next_idx;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
